// File: rtl/lowp_pkg.sv
// rtl/lowp_pkg.sv - shared states, coefficient map and default coefficients for lowp_sched
package lowp_pkg;

  // Eight-cycle sample pipeline: IDLE -> LOAD -> MAC0..MAC4 -> WRITE.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC0,
    ST_MAC1,
    ST_MAC2,
    ST_MAC3,
    ST_MAC4,
    ST_WRITE
  } state_e;

  localparam int NCOEF = 5;

  // Coefficient write addresses.
  localparam logic [2:0] ADDR_B1 = 3'd0;
  localparam logic [2:0] ADDR_B2 = 3'd1;
  localparam logic [2:0] ADDR_B3 = 3'd2;
  localparam logic [2:0] ADDR_A2 = 3'd3;
  localparam logic [2:0] ADDR_A3 = 3'd4;

  // Coefficients are Q2.30, so products are rescaled by 30 bits.
  localparam int QSHIFT = 30;
  localparam int ACC_W  = 64;

  localparam logic signed [31:0] DEF_B1 = 32'sd104;
  localparam logic signed [31:0] DEF_B2 = 32'sd208;
  localparam logic signed [31:0] DEF_B3 = 32'sd104;
  localparam logic signed [31:0] DEF_A2 = -32'sd2146742848;
  localparam logic signed [31:0] DEF_A3 = 32'sd1073001490;

  function automatic logic signed [31:0] def_coef(input int idx);
    case (idx)
      0:       return DEF_B1;
      1:       return DEF_B2;
      2:       return DEF_B3;
      3:       return DEF_A2;
      default: return DEF_A3;
    endcase
  endfunction

  // Width of a channel index; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lowp_rr_arb.sv
// rtl/lowp_rr_arb.sv - round-robin request arbiter, search starts after the last grant
module lowp_rr_arb
  import lowp_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic          clock_in,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          take,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [7:0]    req_pad;
  logic [3:0]    cand;

  // Scan from the pointer upward with wrap; the first pending request wins.
  always_comb begin
    req_pad = 8'(req);
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = 4'(ptr_q) + 4'(i);
      if (cand >= 4'(N)) cand = cand - 4'(N);
      if (!gnt_any && req_pad[cand[2:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[IW-1:0];
      end
    end
  end

  // Advance the pointer past the winner only when the grant is actually taken.
  always_comb begin
    ptr_d = ptr_q;
    if (take && gnt_any) begin
      ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  // Pointer register; channel 0 has priority after reset.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/lowp_sched.sv
// rtl/lowp_sched.sv - shared biquad low-pass scheduler over NCH channels; LOWP_SCHED_SAT_EN selects output saturation
module lowp_sched
  import lowp_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = 28,
  parameter int CW  = 32
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH*DW-1:0] req_data,
  output logic [NCH-1:0]    req_ack,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [CW-1:0]     cfg_data,
  output logic              cfg_ready,
  output logic              out_valid,
  output logic [2:0]        out_chan,
  output logic [DW-1:0]     out_data
);

  localparam int IW = idx_width(NCH);
  localparam int PW = CW + DW;

  state_e                 state_q, state_d;
  logic [IW-1:0]          chan_q, chan_d;
  logic signed [DW-1:0]   x_q, x_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [CW-1:0]   coef_q [NCOEF];
  logic signed [CW-1:0]   coef_d [NCOEF];
  logic signed [DW-1:0]   x1_q [NCH];
  logic signed [DW-1:0]   x1_d [NCH];
  logic signed [DW-1:0]   x2_q [NCH];
  logic signed [DW-1:0]   x2_d [NCH];
  logic signed [DW-1:0]   y1_q [NCH];
  logic signed [DW-1:0]   y1_d [NCH];
  logic signed [DW-1:0]   y2_q [NCH];
  logic signed [DW-1:0]   y2_d [NCH];
  logic [NCH-1:0]         req_ack_q, req_ack_d;
  logic                   out_valid_q, out_valid_d;
  logic [2:0]             out_chan_q, out_chan_d;
  logic [DW-1:0]          out_data_q, out_data_d;
  logic                   cfg_ready_q, cfg_ready_d;

  logic [IW-1:0]           arb_idx;
  logic                    arb_any;
  logic                    arb_take;
  logic signed [CW-1:0]    mul_c;
  logic signed [DW-1:0]    mul_s;
  logic                    mul_sub;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [DW-1:0]    y;
  logic                    unused_acc;

  lowp_rr_arb #(.N(NCH), .IW(IW)) u_arb (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .req      (req_valid),
    .take     (arb_take),
    .gnt_idx  (arb_idx),
    .gnt_any  (arb_any)
  );

  // Operand select for the single shared multiplier; feedback terms are subtracted.
  always_comb begin
    mul_c   = '0;
    mul_s   = '0;
    mul_sub = 1'b0;
    case (state_q)
      ST_MAC0: begin mul_c = coef_q[ADDR_B1]; mul_s = x_q;          end
      ST_MAC1: begin mul_c = coef_q[ADDR_B2]; mul_s = x1_q[chan_q]; end
      ST_MAC2: begin mul_c = coef_q[ADDR_B3]; mul_s = x2_q[chan_q]; end
      ST_MAC3: begin mul_c = coef_q[ADDR_A2]; mul_s = y1_q[chan_q]; mul_sub = 1'b1; end
      ST_MAC4: begin mul_c = coef_q[ADDR_A3]; mul_s = y2_q[chan_q]; mul_sub = 1'b1; end
      default: ;
    endcase
  end

  assign prod     = PW'(mul_c) * PW'(mul_s);
  assign prod_ext = ACC_W'(prod);

`ifdef LOWP_SCHED_SAT_EN
  localparam logic signed [ACC_W-1:0] Y_MAX = (ACC_W'(1) <<< (DW - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] Y_MIN = -(ACC_W'(1) <<< (DW - 1));
  logic signed [ACC_W-1:0] acc_sh;

  // Rescale and clamp to the representable sample range.
  always_comb begin
    acc_sh = acc_q >>> QSHIFT;
    if (acc_sh > Y_MAX)      y = Y_MAX[DW-1:0];
    else if (acc_sh < Y_MIN) y = Y_MIN[DW-1:0];
    else                     y = acc_sh[DW-1:0];
  end

  assign unused_acc = ^acc_q[QSHIFT-1:0];
`else
  // Rescale by truncation, keeping the accumulator sign as the sample sign.
  always_comb begin
    y = {acc_q[ACC_W-1], acc_q[QSHIFT+DW-2:QSHIFT]};
  end

  assign unused_acc = ^{acc_q[QSHIFT-1:0], acc_q[ACC_W-2:QSHIFT+DW-1]};
`endif

  // Next-state and datapath: config and grant in IDLE, then one product per MAC cycle.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    x_d         = x_q;
    acc_d       = acc_q;
    coef_d      = coef_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    req_ack_d   = '0;
    out_valid_d = 1'b0;
    out_chan_d  = out_chan_q;
    out_data_d  = out_data_q;
    arb_take    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_we) begin
          if (cfg_ready_q && (cfg_addr <= ADDR_A3)) coef_d[cfg_addr] = cfg_data;
        end else if (arb_any) begin
          arb_take           = 1'b1;
          chan_d             = arb_idx;
          req_ack_d[arb_idx] = 1'b1;
          state_d            = ST_LOAD;
        end
      end
      ST_LOAD: begin
        x_d     = req_data[chan_q*DW +: DW];
        acc_d   = '0;
        state_d = ST_MAC0;
      end
      ST_MAC0, ST_MAC1, ST_MAC2, ST_MAC3, ST_MAC4: begin
        acc_d = mul_sub ? (acc_q - prod_ext) : (acc_q + prod_ext);
        case (state_q)
          ST_MAC0: state_d = ST_MAC1;
          ST_MAC1: state_d = ST_MAC2;
          ST_MAC2: state_d = ST_MAC3;
          ST_MAC3: state_d = ST_MAC4;
          default: state_d = ST_WRITE;
        endcase
      end
      ST_WRITE: begin
        out_valid_d  = 1'b1;
        out_chan_d   = 3'(chan_q);
        out_data_d   = y;
        x2_d[chan_q] = x1_q[chan_q];
        x1_d[chan_q] = x_q;
        y2_d[chan_q] = y1_q[chan_q];
        y1_d[chan_q] = y;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    cfg_ready_d = (state_d == ST_IDLE);
  end

  // State register; reset aborts any sample in flight and restores default coefficients.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      chan_q      <= '0;
      x_q         <= '0;
      acc_q       <= '0;
      req_ack_q   <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_data_q  <= '0;
      cfg_ready_q <= 1'b0;
      for (int i = 0; i < NCOEF; i++) coef_q[i] <= CW'(def_coef(i));
      for (int i = 0; i < NCH; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      req_ack_q   <= req_ack_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_data_q  <= out_data_d;
      cfg_ready_q <= cfg_ready_d;
      coef_q      <= coef_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
    end
  end

  assign req_ack   = req_ack_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_data  = out_data_q;
  assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_lowp_sched.sv
// tb/tb_lowp_sched.sv - randomized and directed bench for lowp_sched against a sample-level filter model
module tb_lowp_sched;

  localparam int NCH = 4;
  localparam int DW  = 28;
  localparam int CW  = 32;

  logic              clock_in = 1'b0;
  logic              reset_n;
  logic [NCH-1:0]    req_valid;
  logic [NCH*DW-1:0] req_data;
  logic [NCH-1:0]    req_ack;
  logic              cfg_we;
  logic [2:0]        cfg_addr;
  logic [CW-1:0]     cfg_data;
  logic              cfg_ready;
  logic              out_valid;
  logic [2:0]        out_chan;
  logic [DW-1:0]     out_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clock_in = ~clock_in;

  lowp_sched #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .out_valid (out_valid),
    .out_chan  (out_chan),
    .out_data  (out_data)
  );

  // Reference model: coefficients, per-channel history and the pending sample.
  longint         coef [5];
  longint         mx1 [NCH];
  longint         mx2 [NCH];
  longint         my1 [NCH];
  longint         my2 [NCH];
  int             ptr;
  int             phase;
  int             cur;
  longint         cur_x;
  logic [NCH-1:0] e_ack;
  logic           e_valid;
  longint         e_chan;
  longint         e_data;
  logic           e_ready;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    coef[0] = 104;
    coef[1] = 208;
    coef[2] = 104;
    coef[3] = -2146742848;
    coef[4] = 1073001490;
    for (int i = 0; i < NCH; i++) begin
      mx1[i] = 0; mx2[i] = 0; my1[i] = 0; my2[i] = 0;
    end
    ptr = 0; phase = 0; cur = 0; cur_x = 0;
    e_ack = '0; e_valid = 1'b0; e_chan = 0; e_data = 0; e_ready = 1'b0;
  endtask

  function automatic longint sample_of(input int ch);
    logic [DW-1:0] t;
    t = req_data[ch*DW +: DW];
    return longint'($signed(t));
  endfunction

  // Q2.30 accumulator to DW-bit sample.
  function automatic longint qout(input longint acc);
    longint sh;
    longint half;
    longint low;
    sh   = acc >>> 30;
    half = longint'(1) << (DW - 1);
    low  = sh & (half - 1);
`ifdef LOWP_SCHED_SAT_EN
    if (sh > half - 1) return half - 1;
    if (sh < -half) return -half;
    return sh;
`else
    return (acc < 0) ? (low - half) : low;
`endif
  endfunction

  function automatic int ohidx(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    int     c;
    int     found;
    longint acc;
    longint yv;
    e_ack   = '0;
    e_valid = 1'b0;
    if (phase == 0) begin
      if (cfg_we) begin
        if (e_ready && cfg_addr < 3'd5) coef[cfg_addr] = longint'($signed(cfg_data));
      end else if (req_valid != '0) begin
        found = 0;
        for (int k = 0; k < NCH; k++) begin
          c = (ptr + k) % NCH;
          if (found == 0 && req_valid[c]) begin
            found = 1;
            cur   = c;
          end
        end
        ptr        = (cur + 1) % NCH;
        e_ack[cur] = 1'b1;
        phase      = 1;
      end
    end else if (phase == 1) begin
      cur_x = sample_of(cur);
      phase = 2;
    end else if (phase == 7) begin
      acc = coef[0] * cur_x + coef[1] * mx1[cur] + coef[2] * mx2[cur]
            - coef[3] * my1[cur] - coef[4] * my2[cur];
      yv       = qout(acc);
      mx2[cur] = mx1[cur];
      mx1[cur] = cur_x;
      my2[cur] = my1[cur];
      my1[cur] = yv;
      e_valid  = 1'b1;
      e_chan   = cur;
      e_data   = yv;
      phase    = 0;
    end else begin
      phase++;
    end
    e_ready = (phase == 0);
  endtask

  // One clock: predict, clock, then compare every output at the falling edge.
  task automatic cycle();
    model_edge();
    @(posedge clock_in);
    @(negedge clock_in);
    cyc++;
    chk("req_ack", req_ack, e_ack);
    chk("out_valid", out_valid, e_valid);
    chk("out_chan", out_chan, e_chan);
    chk("out_data", longint'($signed(out_data)), e_data);
    chk("cfg_ready", cfg_ready, e_ready);
  endtask

  task automatic do_reset();
    #2;
    reset_n   = 1'b0;
    req_valid = '0;
    cfg_we    = 1'b0;
    model_reset();
    #1;
    chk("rst_ack", req_ack, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_chan", out_chan, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ready", cfg_ready, 0);
    @(negedge clock_in);
    @(negedge clock_in);
    reset_n = 1'b1;
    cycle();
  endtask

  task automatic cfg_write(input int addr, input logic [CW-1:0] data);
    cfg_we   = 1'b1;
    cfg_addr = 3'(addr);
    cfg_data = data;
    cycle();
    cfg_we   = 1'b0;
  endtask

  task automatic set_coefs(input logic [CW-1:0] b1, input logic [CW-1:0] b2, input logic [CW-1:0] b3,
                           input logic [CW-1:0] a2, input logic [CW-1:0] a3);
    cfg_write(0, b1);
    cfg_write(1, b2);
    cfg_write(2, b3);
    cfg_write(3, a2);
    cfg_write(4, a3);
  endtask

  task automatic set_sample(input int ch, input longint v);
    req_data[ch*DW +: DW] = DW'(v);
    req_valid[ch]         = 1'b1;
  endtask

  task automatic wait_ack(input int ch);
    int n;
    n = 0;
    while (!req_ack[ch] && n < 40) begin cycle(); n++; end
    chk("ack_seen", req_ack[ch], 1);
    req_valid[ch] = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin cycle(); n++; end
    chk("out_seen", out_valid, 1);
    lat = n;
  endtask

  task automatic send(input int ch, input longint v, output longint y, output int lat);
    set_sample(ch, v);
    wait_ack(ch);
    wait_out(lat);
    y = longint'($signed(out_data));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    longint   y;
    int       lat;
    int       nack;
    int       last;
    int       order [5];
    longint   ysat1;
    longint   ysat2;

    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    do_reset();

    // Unity gain, latency from ack to result.
    set_coefs(32'h40000000, 0, 0, 0, 0);
    send(2, 12345, y, lat);
    chk("unity_data", y, 12345);
    chk("unity_chan", out_chan, 2);
    chk("unity_lat", lat, 7);

    // First-order recursion y = x + y1.
    set_coefs(32'h40000000, 0, 0, 32'hC0000000, 0);
    send(1, 5, y, lat);
    chk("rec_1", y, 5);
    send(1, 5, y, lat);
    chk("rec_2", y, 10);
    send(1, 5, y, lat);
    chk("rec_3", y, 15);
    send(0, 7, y, lat);
    chk("rec_other", y, 7);

    // Round-robin order and spacing with every channel pending.
    do_reset();
    for (int i = 0; i < NCH; i++) set_sample(i, 1000 * (i + 1));
    order = '{0, 1, 2, 3, 0};
    nack  = 0;
    last  = 0;
    for (int t = 0; t < 60 && nack < 5; t++) begin
      cycle();
      if (req_ack != '0) begin
        chk("rr_chan", ohidx(req_ack), order[nack]);
        if (nack > 0) chk("rr_gap", cyc - last, 8);
        last = cyc;
        nack++;
      end
    end
    chk("rr_count", nack, 5);
    req_valid = '0;
    repeat (8) cycle();

    // Large gains: truncation or saturation of the output.
    do_reset();
    set_coefs(32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 0);
    send(3, 134217727, y, lat);
    ysat1 = y;
    send(3, 134217727, y, lat);
    ysat2 = y;
`ifdef LOWP_SCHED_SAT_EN
    chk("sat_first", ysat1, 134217727);
    chk("sat_second", ysat2, 134217727);
`else
    chk("trunc_first", ysat1, 134217725);
    chk("trunc_second", ysat2, 134217723);
`endif

    // Config writes are locked out mid-sample; write plus request in IDLE delays the grant.
    set_coefs(32'h40000000, 0, 0, 0, 0);
    set_sample(0, 100);
    wait_ack(0);
    repeat (3) cycle();
    chk("lock_ready", cfg_ready, 0);
    cfg_we   = 1'b1;
    cfg_addr = 3'd0;
    cfg_data = 32'h20000000;
    cycle();
    cfg_we   = 1'b0;
    wait_out(lat);
    chk("lock_keep", longint'($signed(out_data)), 100);
    cfg_we   = 1'b1;
    cfg_addr = 3'd0;
    cfg_data = 32'h20000000;
    set_sample(0, 100);
    cycle();
    chk("same_noack", req_ack, 0);
    cfg_we = 1'b0;
    cycle();
    chk("same_ack", req_ack[0], 1);
    req_valid[0] = 1'b0;
    wait_out(lat);
    chk("same_half", longint'($signed(out_data)), 50);
    cfg_write(7, 32'h40000000);
    cfg_write(5, 32'h00000000);
    send(0, 100, y, lat);
    chk("oor_addr", y, 50);

    // Reset during MAC3 discards the sample and clears history.
    set_coefs(32'h40000000, 0, 0, 32'hC0000000, 0);
    send(1, 9, y, lat);
    chk("pre_rst", y, 9);
    set_sample(1, 20);
    wait_ack(1);
    repeat (4) cycle();
    do_reset();
    repeat (10) begin
      cycle();
      chk("abort_noout", out_valid, 0);
    end
    set_coefs(32'h40000000, 0, 0, 32'hC0000000, 0);
    send(1, 7, y, lat);
    chk("rst_state", y, 7);

    // Random traffic: arrivals, withdrawals and config writes including bad addresses.
    do_reset();
    for (int t = 0; t < 1500; t++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (e_ack[ch]) begin
          req_valid[ch] = 1'b0;
        end else if (req_valid[ch] && $urandom_range(0, 15) == 0) begin
          req_valid[ch] = 1'b0;
        end else if (!req_valid[ch] && $urandom_range(0, 3) == 0) begin
          req_data[ch*DW +: DW] = DW'($urandom);
          req_valid[ch]         = 1'b1;
        end
      end
      if ($urandom_range(0, 9) == 0) begin
        cfg_we   = 1'b1;
        cfg_addr = 3'($urandom_range(0, 7));
        cfg_data = $urandom;
      end else begin
        cfg_we = 1'b0;
      end
      cycle();
    end
    req_valid = '0;
    cfg_we    = 1'b0;
    repeat (10) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lowp_sched.md
LOWP_SCHED -- requirements
Module: lowp_sched

Interface
REQ-001 Parameter NCH, default 4: number of requesting channels, 2..8.
REQ-002 Parameter DW, default 28: signed sample width.
REQ-003 Parameter CW, default 32: signed coefficient width, Q2.30.
REQ-004 clock_in  in  1  sole clock; all logic on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  NCH  per-channel sample-pending flag; held until acknowledged.
REQ-007 req_data  in  NCH*DW  per-channel signed sample, packed, channel 0 in the LSBs.
REQ-008 req_ack  out  NCH  one-hot, one-cycle pulse when that channel's sample is taken.
REQ-009 cfg_we, cfg_addr[2:0], cfg_data[CW-1:0]  in  coefficient write: addr 0..4 = b1,b2,b3,a2,a3.
REQ-010 cfg_ready  out  1  high only in IDLE; writes with cfg_ready low are ignored.
REQ-011 out_valid  out  1  one-cycle result strobe.
REQ-012 out_chan  out  3  channel of the result; out_data  out  DW  signed filtered sample.

Function
REQ-013 One shared 32x28 multiplier and 64-bit accumulator shall serve all channels; per-channel state x1,x2,y1,y2 (DW each) shall be held in a state array.
REQ-014 FSM: IDLE -> LOAD -> MAC0..MAC4 -> WRITE -> IDLE, exactly 8 cycles per sample.
REQ-015 IDLE: if cfg_we is high, apply the write and stay in IDLE; otherwise, if any req_valid is high, grant one channel and go to LOAD.
REQ-016 Grant is round-robin: search starts at the channel after the last granted one; after reset, channel 0 has highest priority.
REQ-017 LOAD: pulse req_ack for the granted channel, latch its sample x, and clear the accumulator.
REQ-018 MAC0..MAC4 add b1*x, b2*x1, b3*x2, -(a2*y1), -(a3*y2) in that order, one product per cycle.
REQ-019 WRITE: y = {acc[63], acc[56:30]} (DW=28 case); assert out_valid with out_chan and out_data=y; update x2<=x1, x1<=x, y2<=y1, y1<=y for the granted channel only.
REQ-020 out_data and out_chan shall hold their values until the next WRITE.
REQ-021 The states of other channels shall be unaffected by a grant.
REQ-022 A req_valid that drops before its grant shall be skipped silently; req_data is sampled only in LOAD.
REQ-023 An out-of-range cfg_addr (5..7) shall be ignored.

Reset
REQ-024 reset_n low shall force IDLE, clear all outputs and the state array to 0, load the default coefficients, and point the round-robin at channel 0.
REQ-025 Default coefficients: b1=104, b2=208, b3=104, a2=-2146742848, a3=1073001490.
REQ-026 A reset during LOAD..WRITE shall abort the sample: no out_valid, no state update.

Configuration
REQ-027 With LOWP_SCHED_SAT_EN defined, y shall saturate to [-2^(DW-1), 2^(DW-1)-1] from acc>>>30.
REQ-028 Without LOWP_SCHED_SAT_EN, y shall be the truncation given in REQ-019.

Structure
REQ-029 Package lowp_pkg shall hold the FSM state enum, the coefficient address constants, the default coefficients, and the Q format shift (30).
REQ-030 Sub-module lowp_rr_arb (NCH-wide round-robin arbiter with a pointer update on grant) shall implement REQ-016.

Verification
REQ-031 Unity: write b1=0x40000000 and the other coefficients 0; ch2 sends 12345 -> out_valid 8 cycles after the grant, out_chan=2, out_data=12345.
REQ-032 Recursion: write b1=0x40000000 and a2=0xC0000000 (others 0); ch1 sends 5 three times -> outputs 5, 10, 15; ch0 then sends 7 -> output 7.
REQ-033 Round-robin: all four channels held valid -> req_ack order 0,1,2,3,0 with an 8-cycle spacing.
REQ-034 Saturation (macro on): write b1=b2=0x7FFFFFFF, then send 134217727 twice -> second output 134217727; macro off -> truncated value per REQ-019.
REQ-035 Config lockout: cfg_we during MAC2 -> coefficient unchanged and cfg_ready=0; cfg_we and req_valid together in IDLE -> write applied, grant on the next cycle.
REQ-036 Reset mid-MAC3 -> no out_valid, and all outputs and state read 0 afterward.
